// File: rtl/vx_fp_sqrt_arb.sv
// vx_fp_sqrt_arb: shares one pipelined, stallable FP square-root unit among
// NUM_REQS requesters. Round-robin issue arbitration, bounded in-flight
// credit, and response routing by the requester index carried in the unit tag.
// Optional performance counters are enabled by defining FSQRT_ARB_PERF_EN.
module vx_fp_sqrt_arb #(
    parameter int NUM_REQS      = 4,
    parameter int LANES         = 1,
    parameter int TAGW          = 1,
    parameter int MAX_INFLIGHT  = 16,
    parameter int INST_FRM_BITS = 3,
    localparam int REQW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int CNTW = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQS-1:0]               req_valid,
    output logic [NUM_REQS-1:0]               req_ready,
    input  logic [NUM_REQS*TAGW-1:0]          req_tag,
    input  logic [NUM_REQS*INST_FRM_BITS-1:0] req_frm,
    input  logic [NUM_REQS*LANES*32-1:0]      req_data,
    output logic [NUM_REQS-1:0]               rsp_valid,
    input  logic [NUM_REQS-1:0]               rsp_ready,
    output logic [TAGW-1:0]                   rsp_tag,
    output logic [LANES*32-1:0]               rsp_data,
    output logic                              sq_valid_in,
    input  logic                              sq_ready_in,
    output logic [REQW+TAGW-1:0]              sq_tag_in,
    output logic [INST_FRM_BITS-1:0]          sq_frm,
    output logic [LANES*32-1:0]               sq_dataa,
    input  logic                              sq_valid_out,
    input  logic [REQW+TAGW-1:0]              sq_tag_out,
    input  logic [LANES*32-1:0]               sq_result,
    output logic                              sq_ready_out,
    output logic                              busy
`ifdef FSQRT_ARB_PERF_EN
    ,
    output logic [NUM_REQS*32-1:0]            perf_stall_cycles,
    output logic [31:0]                       perf_credit_stalls
`endif
);

    logic [REQW-1:0] rr_ptr;
    logic [CNTW-1:0] inflight_cnt;
    logic [REQW-1:0] winner;
    logic [REQW-1:0] scan_idx;
    logic [REQW-1:0] rsp_idx;
    logic            found;
    logic            credit_ok;
    logic            issue_fire;
    logic            rsp_fire;

    // Round-robin scan starting at rr_ptr; first valid requester wins.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            scan_idx = REQW'((32'(rr_ptr) + i) % NUM_REQS);
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    // Credit uses the registered count, so a same-cycle response never unblocks issue.
    always_comb begin
        credit_ok   = 32'(inflight_cnt) < MAX_INFLIGHT;
        sq_valid_in = reset & found & credit_ok;
        issue_fire  = sq_valid_in & sq_ready_in;
        busy        = reset & (inflight_cnt != '0);
    end

    // Winner payload mux and grant; payload is independent of sq_ready_in.
    always_comb begin
        req_ready = '0;
        sq_tag_in = '0;
        sq_frm    = '0;
        sq_dataa  = '0;
        for (int unsigned j = 0; j < NUM_REQS; j++) begin
            if (reset && winner == REQW'(j)) begin
                req_ready[j] = found & sq_ready_in & credit_ok;
                sq_tag_in    = {winner, req_tag[j*TAGW +: TAGW]};
                sq_frm       = req_frm[j*INST_FRM_BITS +: INST_FRM_BITS];
                sq_dataa     = req_data[j*LANES*32 +: LANES*32];
            end
        end
    end

    // Route unit output to the requester named by the tag's index field.
    always_comb begin
        rsp_idx      = sq_tag_out[REQW+TAGW-1:TAGW];
        rsp_valid    = '0;
        sq_ready_out = 1'b0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (rsp_idx == REQW'(i)) begin
                rsp_valid[i] = reset & sq_valid_out;
                sq_ready_out = reset & rsp_ready[i];
            end
        end
        rsp_tag  = reset ? sq_tag_out[TAGW-1:0] : '0;
        rsp_data = reset ? sq_result : '0;
        rsp_fire = sq_valid_out & sq_ready_out;
    end

    // Round-robin pointer and in-flight counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr       <= '0;
            inflight_cnt <= '0;
        end else begin
            if (issue_fire) begin
                rr_ptr <= (32'(winner) == NUM_REQS - 1) ? '0 : winner + 1'b1;
            end
            if (issue_fire && !rsp_fire) begin
                inflight_cnt <= inflight_cnt + 1'b1;
            end else if (!issue_fire && rsp_fire) begin
                inflight_cnt <= inflight_cnt - 1'b1;
            end
        end
    end

    // Illegal response index and counter over/underflow must never occur.
    rsp_idx_legal: assert property (@(posedge clk) disable iff (!reset)
        sq_valid_out |-> (32'(rsp_idx) < NUM_REQS));
    cnt_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(issue_fire && !rsp_fire && 32'(inflight_cnt) == MAX_INFLIGHT));
    cnt_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        !(rsp_fire && !issue_fire && inflight_cnt == '0));

`ifdef FSQRT_ARB_PERF_EN
    logic [31:0] stall_cnt [NUM_REQS];
    logic [31:0] credit_stall_cnt;

    // Per-requester stall cycles and credit-blocked cycles, wrapping at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REQS; i++) begin
                stall_cnt[i] <= '0;
            end
            credit_stall_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQS; i++) begin
                if (req_valid[i] && !req_ready[i]) begin
                    stall_cnt[i] <= stall_cnt[i] + 32'd1;
                end
            end
            if ((|req_valid) && !credit_ok) begin
                credit_stall_cnt <= credit_stall_cnt + 32'd1;
            end
        end
    end

    // Flatten counters onto the output ports.
    always_comb begin
        perf_stall_cycles = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            perf_stall_cycles[i*32 +: 32] = stall_cnt[i];
        end
        perf_credit_stalls = credit_stall_cnt;
    end
`endif

endmodule
